// File: rtl/gr_timer.sv
// gr_timer: 16-bit programmable interval timer for the gr0040 I/O bus.
// Four word registers (RELOAD, COUNT, CTRL, STATUS) with a down-counter
// that raises a sticky, maskable interrupt on every expiry, in either
// one-shot or periodic mode. Single clock, synchronous active-high reset.
// The read-data port is named dout because "do" is a reserved word.
module gr_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sel,
    input  logic         sw,
    input  logic         lw,
    input  logic [1:0]   ad,
    input  logic [W-1:0] di,
    output logic [W-1:0] dout,
    output logic         rdy,
    output logic         intreq
);

    localparam logic [1:0]   AD_RELOAD = 2'd0;
    localparam logic [1:0]   AD_COUNT  = 2'd1;
    localparam logic [1:0]   AD_CTRL   = 2'd2;
    localparam logic [1:0]   AD_STATUS = 2'd3;
    localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [W-1:0] r_reload;
    logic [W-1:0] r_count;
    logic         r_en;
    logic         r_ie;
    logic         r_per;
    logic         r_pend;

    // Bus decode and counter conditions
    logic         w_wr;
    logic         w_rd;
    logic         w_wr_reload;
    logic         w_wr_count;
    logic         w_wr_ctrl;
    logic         w_w1c;
    logic         w_count_nz;
    logic         w_expire;
    logic [W-1:0] w_count_nxt;
    logic [W-1:0] w_rd_data;

    assign w_wr        = sel & sw;
    assign w_rd        = sel & lw;
    assign w_wr_reload = w_wr & (ad == AD_RELOAD);
    assign w_wr_count  = w_wr & (ad == AD_COUNT);
    assign w_wr_ctrl   = w_wr & (ad == AD_CTRL);
    assign w_w1c       = w_wr & (ad == AD_STATUS) & di[0];

    // C == 0 while enabled is the expiry event, so the decrement never wraps.
    assign w_count_nz  = (r_count != '0);
    assign w_expire    = r_en & ~w_count_nz;

    // Next count: a bus write wins, otherwise decrement or reload on expiry.
    // The reload uses the current RELOAD, so a same-cycle RELOAD write only
    // takes effect from the following expiry. One-shot expiry leaves C at 0.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = di;
        end else if (r_en) begin
            if (w_count_nz) begin
                w_count_nxt = r_count - ONE;
            end else if (r_per) begin
                w_count_nxt = r_reload;
            end
        end
    end

    // RELOAD register: plain software-written value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= '0;
        end else if (w_wr_reload) begin
            r_reload <= di;
        end
    end

    // COUNT register: follows the next-count selection every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // CTRL register: a software write overrides the one-shot auto-disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_per <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en  <= di[0];
            r_ie  <= di[1];
            r_per <= di[2];
        end else if (w_expire && !r_per) begin
            r_en  <= 1'b0;
        end
    end

    // PEND flag: set on expiry, cleared by write-1; a coincident expiry wins
    // so an interrupt is never lost to a late acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_expire) begin
            r_pend <= 1'b1;
        end else if (w_w1c) begin
            r_pend <= 1'b0;
        end
    end

    // Read mux: zero when not reading so the result can be OR-merged on the bus.
    always_comb begin
        w_rd_data = '0;
        if (w_rd) begin
            case (ad)
                AD_RELOAD: w_rd_data = r_reload;
                AD_COUNT:  w_rd_data = r_count;
                AD_CTRL:   w_rd_data = {{(W-3){1'b0}}, r_per, r_ie, r_en};
                default:   w_rd_data = {{(W-1){1'b0}}, r_pend};
            endcase
        end
    end

    assign dout   = w_rd_data;
    assign rdy    = sel;
    // Interrupt is a pure function of registered state.
    assign intreq = r_pend & r_ie;

endmodule

// File: tb/tb_gr_timer.sv
// tb_gr_timer: table-driven, directed and randomized checks of gr_timer
// against a register-level reference model kept in the bench.
module tb_gr_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         sw;
    logic         lw;
    logic [1:0]   ad;
    logic [W-1:0] di;
    logic [W-1:0] dout;
    logic         rdy;
    logic         intreq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [W-1:0] m_r, m_c;
    logic         m_en, m_ie, m_per, m_pend;

    // Last sampled DUT outputs
    logic [W-1:0] a_do;
    logic         a_rdy, a_int;

    typedef struct {
        logic         s;
        logic         w;
        logic         l;
        logic [1:0]   a;
        logic [W-1:0] d;
        logic [W-1:0] e_do;
        logic         e_rdy;
        logic         e_int;
    } vec_t;

    vec_t tbl[22];

    gr_timer #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .sw     (sw),
        .lw     (lw),
        .ad     (ad),
        .di     (di),
        .dout   (dout),
        .rdy    (rdy),
        .intreq (intreq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_r;
            2'd1:    return m_c;
            2'd2:    return {13'b0, m_per, m_ie, m_en};
            default: return {15'b0, m_pend};
        endcase
    endfunction

    task automatic model_reset();
        m_r = '0; m_c = '0; m_en = 0; m_ie = 0; m_per = 0; m_pend = 0;
    endtask

    // One clock of the timer rules: counting first, then bus writes layered on
    // top (writes beat counting), except that an expiry always leaves PEND set.
    task automatic model_step(input logic s, input logic w, input logic [1:0] a,
                              input logic [W-1:0] d);
        logic [W-1:0] nr, nc;
        logic         nen, nie, nper, npend;
        logic         wr;
        wr = s & w;
        nr = m_r; nc = m_c; nen = m_en; nie = m_ie; nper = m_per; npend = m_pend;
        if (wr && a == 2'd3 && d[0]) npend = 1'b0;
        if (m_en) begin
            if (m_c != 0) begin
                nc = m_c - 16'd1;
            end else begin
                npend = 1'b1;
                if (m_per) nc = m_r;
                else nen = 1'b0;
            end
        end
        if (wr && a == 2'd0) nr = d;
        if (wr && a == 2'd1) nc = d;
        if (wr && a == 2'd2) begin
            nen = d[0]; nie = d[1]; nper = d[2];
        end
        m_r = nr; m_c = nc; m_en = nen; m_ie = nie; m_per = nper; m_pend = npend;
    endtask

    // One bus cycle: inputs applied after a rising edge, combinational outputs
    // sampled on the falling edge, intreq sampled just after the next rising edge.
    task automatic drive(input logic s, input logic w, input logic l,
                         input logic [1:0] a, input logic [W-1:0] d);
        logic [W-1:0] e_do;
        sel = s; sw = w; lw = l; ad = a; di = d;
        @(negedge clk);
        a_do  = dout;
        a_rdy = rdy;
        e_do  = (s && l) ? model_read(a) : '0;
        chk("model_do", a_do, e_do);
        chk("model_rdy", a_rdy, s);
        @(posedge clk);
        #1;
        cyc++;
        model_step(s, w, a, d);
        a_int = intreq;
        chk("model_intreq", a_int, m_pend & m_ie);
        sel = 0; sw = 0; lw = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        drive(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(1'b1, 1'b0, 1'b1, a, '0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1; sel = 0; sw = 0; lw = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            model_reset();
            chk("reset_intreq", intreq, 1'b0);
        end
        rst = 0;
    endtask

    initial begin
        int t0, last, nper, clr_at;
        logic prev, found;

        rst = 1; sel = 0; sw = 0; lw = 0; ad = 0; di = 0;
        a_int = 0;
        model_reset();

        // Hand-derived vectors starting from reset
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0003, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0003, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 16'h0002, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0002, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd2, 16'hFFF8, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0003, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0002, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0001, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0002, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h0000, 16'h0001, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h0007, 16'h0003, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0007, 1'b1, 1'b0};

        @(posedge clk);
        #1;
        do_reset(2);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].s, tbl[i].w, tbl[i].l, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d_do", i), a_do, tbl[i].e_do);
            chk($sformatf("vec%0d_rdy", i), a_rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d_intreq", i), a_int, tbl[i].e_int);
        end

        // Periodic: RELOAD=COUNT=19, interrupt every 20 cycles, acked 3 cycles in
        wr(2'd2, 16'd0);
        wr(2'd3, 16'd1);
        wr(2'd0, 16'd19);
        wr(2'd1, 16'd19);
        wr(2'd2, 16'd7);
        t0 = cyc; last = t0; nper = 0; clr_at = -1; prev = 1'b0;
        for (int i = 0; i < 200 && nper < 5; i++) begin
            if (cyc + 1 == clr_at) wr(2'd3, 16'd1);
            else idle();
            if (a_int && !prev) begin
                chk("per_interval", cyc - last, 20);
                last = cyc;
                nper++;
                clr_at = cyc + 3;
            end
            prev = a_int;
        end
        chk("per_periods", nper, 5);

        // One-shot: COUNT=5, CTRL=3 -> intreq 6 cycles after the CTRL write
        wr(2'd2, 16'd0);
        wr(2'd3, 16'd1);
        wr(2'd1, 16'd5);
        wr(2'd2, 16'd3);
        t0 = cyc; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle();
            if (a_int) begin
                found = 1'b1;
                chk("oneshot_delay", cyc - t0, 6);
            end
        end
        chk("oneshot_seen", found, 1'b1);
        rd(2'd2);
        chk("oneshot_ctrl", a_do, 16'd2);
        rd(2'd1);
        chk("oneshot_count", a_do, 16'd0);
        wr(2'd3, 16'd1);
        for (int i = 0; i < 50; i++) begin
            idle();
            chk("oneshot_quiet", a_int, 1'b0);
        end

        // Mask: IE=0 keeps intreq low while PEND sets; enabling IE shows it
        wr(2'd0, 16'd3);
        wr(2'd1, 16'd3);
        wr(2'd2, 16'd5);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("mask_intreq", a_int, 1'b0);
        end
        rd(2'd3);
        chk("mask_status", a_do, 16'd1);
        wr(2'd2, 16'd7);
        chk("mask_unmask", a_int, 1'b1);

        // Collision: expiry every cycle beats W1C; COUNT write beats reload
        wr(2'd0, 16'd0);
        wr(2'd1, 16'd0);
        for (int i = 0; i < 10; i++) begin
            wr(2'd3, 16'd1);
            chk("coll_intreq", a_int, 1'b1);
        end
        wr(2'd1, 16'd9);
        rd(2'd1);
        chk("coll_count", a_do, 16'd9);

        // Reset mid-operation with PEND=1 and C=7
        wr(2'd0, 16'd19);
        wr(2'd1, 16'd0);
        for (int i = 0; i < 60; i++) begin
            if (m_c == 16'd8 && m_pend) break;
            idle();
        end
        rd(2'd1);
        chk("mid_count", a_do, 16'd8);
        chk("mid_intreq", a_int, 1'b1);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            chk($sformatf("mid_reg%0d", i), a_do, 16'd0);
        end
        for (int i = 0; i < 50; i++) begin
            idle();
            chk("mid_quiet", a_int, 1'b0);
        end
        rd(2'd1);
        chk("mid_count_held", a_do, 16'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic         s, w, l;
            logic [1:0]   a;
            logic [W-1:0] d;
            s = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            l = $urandom_range(0, 1);
            a = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
            drive(s, w, l, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gr_timer.md
# gr_timer

16-bit programmable interval timer peripheral for the gr0040 SoC. It sits on the processor's I/O data bus alongside the parallel port. It drives the processor's interrupt request input, so the processor's periodic `intreq` comes from hardware rather than the bench. Software programs a reload value and a mode, and the timer raises a sticky, maskable interrupt on each expiry.

## Interface
Parameters:
- `W`, 16: counter and data-bus width.

Ports:
- `clk`, in, 1: single clock, rising edge. One clock; all state is in this domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `sel`, in, 1: timer selected by the I/O address decode for this cycle.
- `sw`, in, 1: store-word strobe; write when `sel & sw`.
- `lw`, in, 1: load-word strobe; read when `sel & lw`.
- `ad`, in, 2: word register select, from `d_ad[2:1]`.
- `di`, in, W: write data.
- `do`, out, W: read data. Equals the selected register when `sel & lw`, else 0, so it can be OR-merged onto the data bus.
- `rdy`, out, 1: equals `sel`; every access completes in one cycle.
- `intreq`, out, 1: interrupt request to the processor, level.

## Operation
Registers, selected by `ad`:
- 0 RELOAD (rw): reload value R.
- 1 COUNT (rw): current count C. A write loads C directly.
- 2 CTRL (rw): bit0 EN, bit1 IE, bit2 PER (periodic). Bits 15:3 read 0 and ignore writes.
- 3 STATUS: bit0 PEND. Reads return {15'b0, PEND}. Writing 1 to bit0 clears PEND; writing 0 has no effect.

Counting, evaluated every cycle with EN=1:
- If C != 0: C <= C-1.
- If C == 0 (expiry): PEND <= 1. If PER=1, C <= R. If PER=0, EN <= 0 and C stays 0 (one-shot).
- If EN=0: C holds and PEND is unchanged by counting.

Interrupt:
- `intreq` = PEND & IE, driven from registered state only (no combinational path from bus inputs).
- Clearing IE masks `intreq` but leaves PEND set.

Precedence when events coincide in one cycle:
- A COUNT write beats decrement and reload.
- A CTRL write beats the one-shot auto-clear of EN.
- Expiry set of PEND beats a same-cycle W1C, so PEND stays 1.
- A RELOAD write in the same cycle as a periodic expiry: C takes the old R; the new R applies from the next expiry.

Arithmetic:
- Unsigned, W bits.
- Decrement never wraps, because C=0 is always handled as expiry.
- Periodic period is R+1 cycles. R=0 gives expiry every cycle.

## Timing
- Reset values: RELOAD=0, COUNT=0, CTRL=0, PEND=0, `intreq`=0. `do`=0 and `rdy`=0 while `sel`=0.
- `rst` asserted mid-count: all state returns to reset values at that edge, and any pending interrupt is dropped.
- Writes take effect at the rising edge where `sel & sw` is sampled. A read in the same cycle as a write returns the pre-write value.
- CTRL write with EN=1 at edge t0 and C=N at t0: the first decrement happens at edge t0+1. Expiry is evaluated at edge t0+N+1, where C=0 is sampled. PEND and `intreq` go high just after that edge.
- Periodic mode: successive PEND rising opportunities are exactly R+1 cycles apart, provided PEND is cleared in between.
- W1C at edge t: PEND and `intreq` low after t, unless an expiry occurs at t.
- No wait states: `rdy` equals `sel` combinationally.

## Test plan
- Reset: hold `rst` 2 cycles, then read all four registers -> each reads 0, and `intreq`=0 throughout.
- Periodic: RELOAD=19, COUNT=19, CTRL=7 (EN|IE|PER); W1C STATUS within 10 cycles of each assertion -> `intreq` rises every 20 cycles, at least 5 periods checked.
- One-shot: COUNT=5, CTRL=3 -> `intreq` rises 6 cycles after the CTRL-write edge; CTRL then reads 2 (EN cleared); COUNT stays 0; no second interrupt in the next 50 cycles.
- Mask: CTRL=5 (IE=0), RELOAD=COUNT=3 -> `intreq` stays 0 while STATUS reads 1. Writing CTRL=7 -> `intreq`=1 the next cycle.
- Collision: RELOAD=COUNT=0, CTRL=7, W1C STATUS every cycle -> PEND and `intreq` remain 1 (set wins). COUNT write of 9 coincident with an expiry -> COUNT reads 9.
- Reset mid-operation: PER run with PEND=1 and C=7, assert `rst` one cycle -> `intreq`=0 and all registers 0 after that edge; no expiry afterwards without reprogramming.
